bcd_display_scanner: RTL
========================

// Module: bcd_display_scanner
// PURPOSE
//  Downstream consumer of the cascaded mod-10 (BCD) digit counters: snapshots a packed
//  multi-digit BCD value on a load strobe and time-multiplexes it onto a common-anode
//  7-segment display. Provides a refresh prescaler, a 1-cycle anti-ghost blank at each
//  digit change, leading-zero blanking, a dash for invalid codes, and a frame pulse.
// PARAMETERS
//  NUM_DIGITS   4      number of display digits; digit 0 = least significant
//  REFRESH_DIV  50000  clk cycles per digit slot; legal range >= 2
//  BLANK_LZ     1      1 = blank leading zeros, 0 = show every digit
// PORTS
//  clk         in   1             system clock, all logic on rising edge
//  rst         in   1             synchronous, active-high reset
//  bcd_in      in   4*NUM_DIGITS  packed BCD, digit k = bcd_in[4k+3:4k]
//  dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit
//  load        in   1             1 = capture bcd_in/dp_in into snapshot this edge
//  an          out  NUM_DIGITS    digit enables, active-low, one-hot-low when on
//  seg         out  7             segments {g,f,e,d,c,b,a}, active-low
//  dp          out  1             decimal point, active-low
//  frame_done  out  1             1-cycle pulse at end of last digit slot
// BEHAVIOUR
//  - One clock, synchronous active-high reset; no other reset source.
//  - Reset: snapshot=0, dp snapshot=0, presc=0, idx=0, an=all 1, seg=7'h7F, dp=1,
//    frame_done=0. Held for every cycle rst=1; rst mid-scan aborts and restarts at idx 0.
//  - Snapshot: load=1 at edge t captures bcd_in/dp_in; bcd_in changes without load
//    never affect the display. Displayed digit reflects new snapshot at edge t+2.
//  - Prescaler presc counts 0..REFRESH_DIV-1 then wraps to 0; on wrap idx advances,
//    NUM_DIGITS-1 wraps to 0.
//  - frame_done=1 for exactly the one cycle following the edge where idx wraps
//    NUM_DIGITS-1 -> 0; period = NUM_DIGITS*REFRESH_DIV cycles.
//  - All outputs registered from (presc, idx, snapshot) of the previous cycle.
//  - Anti-ghost: while registered presc==0, an=all 1 (seg/dp already show new digit).
//    Otherwise an[idx]=0, other bits 1.
//  - Decode (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000
//    4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000;
//    codes 10..15 -> dash 0111111.
//  - Leading-zero blank (BLANK_LZ=1): digit k>0 shows seg=1111111 when snapshot digits
//    NUM_DIGITS-1..k are all 4'd0. Digit 0 is never blanked. Invalid code counts
//    as non-zero. dp follows its dp snapshot even when digit blanked.
//  - load coincident with slot boundary: boundary taken normally, new data used per
//    the t+2 rule; no slot lengthened or skipped.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_LZ=1 unless stated)
//  1 rst=1 for 3 cycles, then hold -> an=4'b1111, seg=7'h7F, dp=1, frame_done=0
//    during rst; first slot after release: 1 blank cycle then an=4'b1110, seg=1000000.
//  2 load bcd_in=16'h1234 -> slots show digit0=0011001(an=1110), 1=0110000(1101),
//    2=0100100(1011), 3=1111001(0111); each slot 1 cycle an=1111 + 3 cycles on;
//    frame_done pulses every 16 cycles.
//  3 load 16'h0042 -> digits 3,2 seg=1111111, digit1=0011001, digit0=0100100;
//    load 16'h0000 -> only digit0 shows 1000000; BLANK_LZ=0 -> all show 1000000.
//  4 load 16'h00A5, dp_in=4'b0010 -> digit1 seg=0111111 with dp=0, digits 3,2 blank,
//    digit0=0010010, dp=1 on all others.
//  5 load once 16'h5678 then toggle bcd_in without load -> display unchanged; load
//    16'h9999 on slot-boundary edge -> 0010000 visible from edge t+2, slot length 4.
//  6 rst pulsed 1 cycle during digit2 slot -> next cycle reset values, snapshot 0,
//    scan restarts at idx 0 with a blank cycle, frame_done period restarts.

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// Bundle between a BCD value source and the multiplexed 7-segment scanner.
// The master supplies the value and load strobe; the slave drives the display lines.
interface bcd_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    modport master (
        output bcd_in, dp_in, load,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, load,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Snapshots a packed BCD value and time-multiplexes it onto a common-anode
// 7-segment display, with one blank cycle per digit change, leading-zero
// blanking, a dash for non-decimal codes and an end-of-frame pulse.
module bcd_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    bcd_display_scanner_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] snap_q;
    logic [NUM_DIGITS-1:0]   dps_q;
    logic [PW-1:0]           presc_q;
    logic [IW-1:0]           idx_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;

    logic                    presc_wrap;
    logic                    idx_last;
    logic [NUM_DIGITS-1:0]   lz;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_lz;

    // Active-low gfedcba; any non-decimal code shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign presc_wrap = (presc_q == PW'(REFRESH_DIV - 1));
    assign idx_last   = (idx_q == IW'(NUM_DIGITS - 1));

    // Digit k is a leading zero when it and every higher digit are 4'd0; digit 0 never is.
    always_comb begin
        logic hi_zero;
        hi_zero = 1'b1;
        lz      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            hi_zero = hi_zero && (snap_q[4*k +: 4] == 4'd0);
            lz[k]   = BLANK_LZ && (k != 0) && hi_zero;
        end
    end

    // Select the digit, decimal point and blank flag of the current slot.
    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_digit = snap_q[4*k +: 4];
                cur_dp    = dps_q[k];
                cur_lz    = lz[k];
            end
        end
    end

    // Next display outputs; the anode stays off for the first cycle of every slot.
    always_comb begin
        an_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((idx_q == IW'(k)) && (presc_q != '0)) begin
                an_d[k] = 1'b0;
            end
        end
        seg_d = cur_lz ? 7'h7F : decode(cur_digit);
        dp_d  = ~cur_dp;
        fd_d  = presc_wrap && idx_last;
    end

    // Snapshot, scan counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q  <= '0;
            dps_q   <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            if (bus.load) begin
                snap_q <= bus.bcd_in;
                dps_q  <= bus.dp_in;
            end
            if (presc_wrap) begin
                presc_q <= '0;
                idx_q   <= idx_last ? '0 : idx_q + IW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fd_q  <= fd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;
endmodule
